// File: rtl/temp_poll_sched.sv
// Periodic poll scheduler for the 1-wire temperature reader. Each conversion
// starts with a reset pulse to the reader, then waits for the rising edge of
// done or a timeout. Good results are latched and checked against alarm
// thresholds with hysteresis. Consecutive timeouts are counted.
module temp_poll_sched #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RST_CYC     = 13,
  parameter int unsigned PERIOD_CYC  = 125000000,
  parameter int unsigned TIMEOUT_CYC = 250000000,
  parameter int unsigned HYST        = 4,
  parameter int unsigned ERR_MAX     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              force_req,
  input  logic [DATA_W-1:0] thr_hi,
  input  logic [DATA_W-1:0] thr_lo,
  output logic              sens_rst,
  input  logic              sens_done,
  input  logic [DATA_W-1:0] sens_data,
  output logic [DATA_W-1:0] temp_val,
  output logic              temp_stb,
  output logic              alarm_hi,
  output logic              alarm_lo,
  output logic              timeout_stb,
  output logic [7:0]        err_cnt,
  output logic              fault,
  output logic              busy
);

  // Two guard bits so that threshold +/- hysteresis cannot overflow.
  localparam int unsigned XW = DATA_W + 2;
  localparam logic signed [XW-1:0] HystX    = XW'(HYST);
  localparam logic [31:0]          PerLast  = 32'(PERIOD_CYC - 1);
  localparam logic [31:0]          TmoLast  = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0]          KickLast = 32'(RST_CYC - 1);

  typedef enum logic [2:0] {StIdle, StKick, StWait, StLatch, StTout, StGap} state_e;

  state_e            state_q, state_d;
  logic [31:0]       per_q, per_d;
  logic [31:0]       tmo_q, tmo_d;
  logic              done_q;
  logic [DATA_W-1:0] temp_q, temp_d;
  logic              temp_stb_q, temp_stb_d;
  logic              alarm_hi_q, alarm_hi_d;
  logic              alarm_lo_q, alarm_lo_d;
  logic [7:0]        err_q, err_d;
  logic              fault_q, fault_d;

  logic                 done_rise;
  logic signed [XW-1:0] val_x, thr_hi_x, thr_lo_x, hi_rel, lo_rel;

  assign done_rise = sens_done & ~done_q;
  assign val_x     = $signed({{2{sens_data[DATA_W-1]}}, sens_data});
  assign thr_hi_x  = $signed({{2{thr_hi[DATA_W-1]}}, thr_hi});
  assign thr_lo_x  = $signed({{2{thr_lo[DATA_W-1]}}, thr_lo});
  assign hi_rel    = thr_hi_x - HystX;
  assign lo_rel    = thr_lo_x + HystX;

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en || force_req) state_d = StKick;
      StKick:  if (tmo_q == KickLast) state_d = StWait;
      StWait: begin
        if (done_rise)             state_d = StLatch;
        else if (tmo_q == TmoLast) state_d = StTout;
      end
      StLatch: state_d = StGap;
      StTout:  state_d = StGap;
      StGap: begin
        if (force_req)             state_d = StKick;
        else if (per_q == PerLast) state_d = en ? StKick : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Counters: period restarts on KICK entry; tmo_q times both KICK and WAIT.
  always_comb begin
    per_d = per_q;
    tmo_d = tmo_q;
    if (state_d == StKick && state_q != StKick) per_d = '0;
    else if (per_q != PerLast)                  per_d = per_q + 32'd1;
    if (state_d != state_q)                                tmo_d = '0;
    else if (state_q == StKick || state_q == StWait)       tmo_d = tmo_q + 32'd1;
  end

  // Result, alarm and error-count updates in LATCH / TOUT.
  always_comb begin
    temp_d     = temp_q;
    temp_stb_d = 1'b0;
    alarm_hi_d = alarm_hi_q;
    alarm_lo_d = alarm_lo_q;
    err_d      = err_q;
    fault_d    = fault_q;
    if (state_q == StLatch) begin
      temp_d     = sens_data;
      temp_stb_d = 1'b1;
      err_d      = '0;
      fault_d    = 1'b0;
      if (val_x > thr_hi_x)    alarm_hi_d = 1'b1;
      else if (val_x < hi_rel) alarm_hi_d = 1'b0;
      if (val_x < thr_lo_x)    alarm_lo_d = 1'b1;
      else if (val_x > lo_rel) alarm_lo_d = 1'b0;
    end else if (state_q == StTout) begin
      err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
      fault_d = (({24'd0, err_q} + 32'd1) >= ERR_MAX);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      per_q      <= '0;
      tmo_q      <= '0;
      done_q     <= 1'b0;
      temp_q     <= '0;
      temp_stb_q <= 1'b0;
      alarm_hi_q <= 1'b0;
      alarm_lo_q <= 1'b0;
      err_q      <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_q      <= per_d;
      tmo_q      <= tmo_d;
      done_q     <= sens_done;
      temp_q     <= temp_d;
      temp_stb_q <= temp_stb_d;
      alarm_hi_q <= alarm_hi_d;
      alarm_lo_q <= alarm_lo_d;
      err_q      <= err_d;
      fault_q    <= fault_d;
    end
  end

  // Decoded from the state register so async reset drops them at once.
  assign sens_rst    = (state_q == StKick);
  assign timeout_stb = (state_q == StTout);
  assign busy        = (state_q != StIdle) && (state_q != StGap);
  assign temp_val    = temp_q;
  assign temp_stb    = temp_stb_q;
  assign alarm_hi    = alarm_hi_q;
  assign alarm_lo    = alarm_lo_q;
  assign err_cnt     = err_q;
  assign fault       = fault_q;

endmodule

// File: doc/temp_poll_sched.md
Name: temp_poll_sched

Overview:
- Periodic scheduler for the 1-wire temperature reader (`temp_1wire`).
- Each conversion is started by a reset pulse on the reader. The block waits for the reader's `done` rising edge, with a timeout.
- On success it latches `T_data` and raises over-/under-temperature alarms with hysteresis. It counts consecutive failures.
- Sits between the reader and the system status/register block, in the 125 MHz domain.

Parameters:
- DATA_W, 16, width of the temperature word (signed, sensor LSB units).
- RST_CYC, 13, cycles that `sens_rst` is held high to start a conversion (≥1).
- PERIOD_CYC, 125000000, cycles from the start of one conversion to the start of the next (1 s).
- TIMEOUT_CYC, 250000000, maximum cycles spent waiting for `done` after `sens_rst` falls.
- HYST, 4, alarm release hysteresis in LSB.
- ERR_MAX, 3, consecutive timeouts that assert `fault`.

Ports:
- clk  in  1  system clock, 125 MHz.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  1 = periodic polling enabled.
- force_req  in  1  single-cycle request for an immediate conversion.
- thr_hi  in  DATA_W  signed upper alarm threshold.
- thr_lo  in  DATA_W  signed lower alarm threshold.
- sens_rst  out  1  active-high start/reset to the reader's `rst`.
- sens_done  in  1  reader `done` level.
- sens_data  in  DATA_W  reader `T_data`.
- temp_val  out  DATA_W  last good temperature.
- temp_stb  out  1  1-cycle pulse when `temp_val` updates.
- alarm_hi  out  1  over-temperature alarm.
- alarm_lo  out  1  under-temperature alarm.
- timeout_stb  out  1  1-cycle pulse on each timeout.
- err_cnt  out  8  consecutive-timeout count, saturating at 255.
- fault  out  1  `err_cnt` ≥ ERR_MAX.
- busy  out  1  state is not IDLE or GAP.

Behaviour:
- Reset (`rst`=0, async) values:
  - state = IDLE.
  - `sens_rst`=0, `temp_val`=0, `temp_stb`=0, `alarm_hi`=0, `alarm_lo`=0, `timeout_stb`=0, `err_cnt`=0, `fault`=0, `busy`=0.
  - Period counter, timeout counter and done-edge register cleared.
- The period counter (32 b) free-runs from the start of each KICK and saturates at PERIOD_CYC-1.
- IDLE:
  - `en`=1 or `force_req`=1 → KICK on the next edge.
- KICK:
  - `sens_rst`=1 for exactly RST_CYC cycles.
  - The period counter resets to 0 on KICK entry.
  - Then → WAIT.
- WAIT:
  - `sens_rst`=0 and the timeout counter increments.
  - Rising edge of `sens_done` (registered previous value 0, current 1) → LATCH.
  - `done` already high on WAIT entry is not an edge.
  - Timeout counter reaching TIMEOUT_CYC-1 without an edge → TOUT.
- LATCH (1 cycle):
  - `temp_val` ← `sens_data`; `temp_stb`=1; `err_cnt` ← 0; `fault` ← 0.
  - Alarms are evaluated on the new value as signed compares:
    - `alarm_hi` set if val > `thr_hi`, cleared if val < `thr_hi`-HYST, otherwise held.
    - `alarm_lo` set if val < `thr_lo`, cleared if val > `thr_lo`+HYST, otherwise held.
  - `temp_stb` and the alarm updates are visible in the cycle after LATCH.
  - → GAP.
- TOUT (1 cycle):
  - `timeout_stb`=1; `err_cnt`++ (saturating); `fault` ← (`err_cnt`+1 ≥ ERR_MAX).
  - `temp_val` and the alarms are held.
  - → GAP.
- GAP:
  - Wait until the period counter = PERIOD_CYC-1, then → KICK if `en`=1, else → IDLE.
  - `force_req` in GAP → KICK on the next edge, cutting the gap short.
- `force_req` while busy (KICK/WAIT/LATCH/TOUT) is ignored and not queued.
- `en` falling during KICK/WAIT completes the current conversion; GAP then → IDLE.
- If WAIT takes longer than PERIOD_CYC, the next KICK issues immediately after LATCH/TOUT. The start-to-start interval is then stretched, with no catch-up.
- Asynchronous reset mid-conversion drops `sens_rst` immediately and discards the conversion.
- Threshold inputs are sampled only in LATCH, so changes between conversions take effect at the next result.
- `temp_stb` and `timeout_stb` are never high in the same cycle.

Test Plan (PERIOD_CYC=1000, TIMEOUT_CYC=500, RST_CYC=13, ERR_MAX=3, HYST=4):
- Normal conversion:
  - Stimulus: release `rst`, `en`=1; sensor model raises `done` 200 cycles after `sens_rst` falls, with data 0x0190.
  - Required: `sens_rst` high for exactly 13 cycles; `temp_val`=0x0190 with one `temp_stb`; next `sens_rst` rise exactly 1000 cycles after the previous one.
- Timeout:
  - Stimulus: sensor never raises `done` for three periods.
  - Required: `timeout_stb` pulses 500 cycles after each `sens_rst` fall; `err_cnt` goes 1,2,3; `fault`=1 after the third; `temp_val` is unchanged.
  - Then a good conversion → `err_cnt`=0 and `fault`=0.
- Alarm hysteresis (`thr_hi`=100):
  - Stimulus: data sequence 101, 98, 95.
  - Required: `alarm_hi`=1, 1, 0.
  - With `thr_lo`=-10, data -11 then -7 → `alarm_lo`=1 then 1; data -5 → 0.
- force_req handling:
  - `force_req` in IDLE with `en`=0 → exactly one conversion, then return to IDLE.
  - `force_req` during WAIT → ignored, no extra `sens_rst`.
  - `force_req` in GAP → KICK on the next edge.
- Reset mid-WAIT:
  - Stimulus: assert `rst` low 100 cycles into WAIT.
  - Required: all outputs return to reset values asynchronously; after release with `en`=1, a fresh 13-cycle KICK occurs.
- Pre-high done:
  - Stimulus: `sens_done` held at 1 across KICK, falling then rising 50 cycles into WAIT.
  - Required: a single LATCH on the second rising edge only.
